// File: rtl/return_write_arbiter_if.sv
// Bundle of the per-writer slave-side AXI write channels and the shared m00 AXI write port.
// "master" is the arbiter's view; "slave" is the view of the writers plus the memory side.
interface return_write_arbiter_if #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned MEM_ADDR_WIDTH = 64,
    parameter int unsigned MEM_DATA_WIDTH = 512
);
    logic [NUM_MASTERS*MEM_ADDR_WIDTH-1:0] s_awaddr;
    logic [NUM_MASTERS*8-1:0]              s_awlen;
    logic [NUM_MASTERS-1:0]                s_awvalid;
    logic [NUM_MASTERS-1:0]                s_awready;
    logic [NUM_MASTERS*MEM_DATA_WIDTH-1:0] s_wdata;
    logic [NUM_MASTERS-1:0]                s_wlast;
    logic [NUM_MASTERS-1:0]                s_wvalid;
    logic [NUM_MASTERS-1:0]                s_wready;
    logic [NUM_MASTERS*2-1:0]              s_bresp;
    logic [NUM_MASTERS-1:0]                s_bvalid;
    logic [NUM_MASTERS-1:0]                s_bready;

    logic [MEM_ADDR_WIDTH-1:0]             m00_axi_awaddr;
    logic [7:0]                            m00_axi_awlen;
    logic                                  m00_axi_awvalid;
    logic                                  m00_axi_awready;
    logic [MEM_DATA_WIDTH-1:0]             m00_axi_wdata;
    logic                                  m00_axi_wlast;
    logic                                  m00_axi_wvalid;
    logic                                  m00_axi_wready;
    logic [1:0]                            m00_axi_bresp;
    logic                                  m00_axi_bvalid;
    logic                                  m00_axi_bready;

    modport master (
        input  s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
               m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
        output s_awready, s_wready, s_bresp, s_bvalid,
               m00_axi_awaddr, m00_axi_awlen, m00_axi_awvalid, m00_axi_wdata,
               m00_axi_wlast, m00_axi_wvalid, m00_axi_bready
    );

    modport slave (
        output s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
               m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               m00_axi_awaddr, m00_axi_awlen, m00_axi_awvalid, m00_axi_wdata,
               m00_axi_wlast, m00_axi_wvalid, m00_axi_bready
    );
endinterface

// File: rtl/return_write_arbiter.sv
// Burst-granular round-robin arbiter sharing one AXI-4 write port among NUM_MASTERS writers.
// A grant is held from AW through B, so bursts from different writers never interleave.
module return_write_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned MEM_ADDR_WIDTH = 64,
    parameter int unsigned MEM_DATA_WIDTH = 512,
    parameter int unsigned IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   system_clk,
    input  logic                   rst,
    return_write_arbiter_if.master bus,
    output logic [NUM_MASTERS-1:0] grant_onehot,
    output logic                   protocol_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    localparam int unsigned CW  = IDX_W + 1;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] grant_oh_q, grant_oh_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;
    logic [7:0]             len_q, len_d;
    logic                   err_q, err_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [CW-1:0]          cand;
    logic [CW-1:0]          rr_next;

    assign grant_onehot = grant_oh_q;
    assign protocol_err = err_q;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NUM_MASTERS)) begin
                cand = cand - CW'(NUM_MASTERS);
            end
            if (!pick_valid && bus.s_awvalid[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        bus.m00_axi_awaddr  = bus.s_awaddr[grant_idx_q*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        bus.m00_axi_awlen   = bus.s_awlen[grant_idx_q*8 +: 8];
        bus.m00_axi_wdata   = bus.s_wdata[grant_idx_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        bus.m00_axi_awvalid = 1'b0;
        bus.m00_axi_wvalid  = 1'b0;
        bus.m00_axi_wlast   = 1'b0;
        bus.m00_axi_bready  = 1'b0;
        bus.s_awready       = '0;
        bus.s_wready        = '0;
        bus.s_bvalid        = '0;
        bus.s_bresp         = {NUM_MASTERS{bus.m00_axi_bresp}};
        case (state_q)
            ADDR: begin
                bus.m00_axi_awvalid         = bus.s_awvalid[grant_idx_q];
                bus.s_awready[grant_idx_q]  = bus.m00_axi_awready;
            end
            DATA: begin
                bus.m00_axi_wvalid          = bus.s_wvalid[grant_idx_q];
                bus.m00_axi_wlast           = bus.s_wlast[grant_idx_q];
                bus.s_wready[grant_idx_q]   = bus.m00_axi_wready;
            end
            RESP: begin
                bus.s_bvalid[grant_idx_q]   = bus.m00_axi_bvalid;
                bus.m00_axi_bready          = bus.s_bready[grant_idx_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        rr_next     = {1'b0, grant_idx_q} + CW'(1);
        if (rr_next >= CW'(NUM_MASTERS)) begin
            rr_next = '0;
        end
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_d           = pick_idx;
                    grant_oh_d            = '0;
                    grant_oh_d[pick_idx]  = 1'b1;
                    state_d               = ADDR;
                end
            end
            ADDR: begin
                if (bus.m00_axi_awvalid && bus.m00_axi_awready) begin
                    len_d      = bus.m00_axi_awlen;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // Length errors are flagged only; wlast alone decides when the burst ends.
                if (bus.m00_axi_wvalid && bus.m00_axi_wready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (bus.m00_axi_wlast) begin
                        if (beat_cnt_q != len_q) begin
                            err_d = 1'b1;
                        end
                        state_d = RESP;
                    end else if (beat_cnt_q == len_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus.m00_axi_bvalid && bus.m00_axi_bready) begin
                    rr_ptr_d   = rr_next[IDX_W-1:0];
                    grant_oh_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_return_write_arbiter.sv
// Scoreboard bench for return_write_arbiter: writer and memory agents drive the bus, expected
// AW/W transfers are queued per scenario and checked in grant order as the m00 port moves them.
module tb_return_write_arbiter;
    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int unsigned   lastpos;
        logic [15:0]   tag;
    } burst_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [NM-1:0] gnt;
    } aw_exp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NM-1:0] grant_onehot;
    logic protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];

    burst_t      plan_q[NM][8];
    int unsigned plan_wr[NM];
    int unsigned plan_rd[NM];
    burst_t      cur[NM];
    bit          active[NM];
    bit          aw_done[NM];
    int unsigned beat[NM];

    int unsigned bcount[NM];
    int unsigned wbeats;
    int unsigned aw_hi;
    int unsigned last_aw_cycles;
    int unsigned aw_wait;
    int unsigned aw_delay;
    bit          wtoggle;
    logic [1:0]  resp_val;

    logic [NM-1:0] aw_f, w_f, b_f;
    logic maw_f, mawv_f, mw_f, mwlast_f, mb_f;

    always #5 clk = ~clk;

    return_write_arbiter_if #(.NUM_MASTERS(NM), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) ifc ();

    return_write_arbiter #(
        .NUM_MASTERS(NM), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)
    ) dut (
        .system_clk(clk), .rst(rst), .bus(ifc.master),
        .grant_onehot(grant_onehot), .protocol_err(protocol_err)
    );

    function automatic logic [DW-1:0] beat_data(input logic [15:0] tag, input int unsigned b);
        return {16'hD00D, tag, 16'(b), ~16'(b)};
    endfunction

    // Writer agents and memory-side agent; they act on handshakes sampled at the previous negedge.
    initial begin
        ifc.s_awaddr = '0; ifc.s_awlen = '0; ifc.s_awvalid = '0; ifc.s_wdata = '0;
        ifc.s_wlast = '0; ifc.s_wvalid = '0; ifc.s_bready = '0;
        ifc.m00_axi_awready = 1'b0; ifc.m00_axi_wready = 1'b0;
        ifc.m00_axi_bresp = 2'b00; ifc.m00_axi_bvalid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                for (int m = 0; m < NM; m++) begin
                    active[m] = 1'b0; aw_done[m] = 1'b0; beat[m] = 0;
                end
                ifc.s_awvalid = '0; ifc.s_wvalid = '0; ifc.s_wlast = '0; ifc.s_bready = '0;
                ifc.m00_axi_awready = 1'b0; ifc.m00_axi_wready = 1'b0; ifc.m00_axi_bvalid = 1'b0;
                aw_wait = 0;
                continue;
            end
            for (int m = 0; m < NM; m++) begin
                if (aw_f[m]) begin ifc.s_awvalid[m] = 1'b0; aw_done[m] = 1'b1; end
                if (w_f[m]) beat[m]++;
                if (b_f[m]) begin active[m] = 1'b0; ifc.s_bready[m] = 1'b0; plan_rd[m]++; end
                if (!active[m] && plan_rd[m] < plan_wr[m]) begin
                    cur[m] = plan_q[m][plan_rd[m]];
                    active[m] = 1'b1; aw_done[m] = 1'b0; beat[m] = 0;
                    ifc.s_awvalid[m] = 1'b1;
                    ifc.s_awaddr[m*AW +: AW] = cur[m].addr;
                    ifc.s_awlen[m*8 +: 8] = cur[m].len;
                end
                if (active[m] && aw_done[m] && beat[m] > cur[m].lastpos) ifc.s_bready[m] = 1'b1;
                ifc.s_wvalid[m] = active[m] && (beat[m] <= cur[m].lastpos);
                ifc.s_wlast[m]  = active[m] && (beat[m] == cur[m].lastpos);
                ifc.s_wdata[m*DW +: DW] = beat_data(cur[m].tag, beat[m]);
            end
            if (maw_f) aw_wait = 0;
            else if (mawv_f) aw_wait++;
            ifc.m00_axi_awready = (aw_wait >= aw_delay);
            ifc.m00_axi_wready = wtoggle ? ~ifc.m00_axi_wready : 1'b1;
            if (mb_f) ifc.m00_axi_bvalid = 1'b0;
            if (mw_f && mwlast_f) begin
                ifc.m00_axi_bvalid = 1'b1;
                ifc.m00_axi_bresp = resp_val;
            end
        end
    end

    // Monitor and scoreboard.
    initial begin
        aw_exp_t ea;
        w_exp_t  ew;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_f = '0; w_f = '0; b_f = '0;
                maw_f = 0; mawv_f = 0; mw_f = 0; mwlast_f = 0; mb_f = 0;
                continue;
            end
            aw_f = ifc.s_awvalid & ifc.s_awready;
            w_f  = ifc.s_wvalid & ifc.s_wready;
            b_f  = ifc.s_bvalid & ifc.s_bready;
            mawv_f   = ifc.m00_axi_awvalid;
            maw_f    = ifc.m00_axi_awvalid & ifc.m00_axi_awready;
            mw_f     = ifc.m00_axi_wvalid & ifc.m00_axi_wready;
            mwlast_f = ifc.m00_axi_wlast;
            mb_f     = ifc.m00_axi_bvalid & ifc.m00_axi_bready;

            n_checks++;
            if (((ifc.s_awready | ifc.s_wready | ifc.s_bvalid) & ~grant_onehot) !== '0) begin
                n_fail++;
                $display("FAIL nongranted_outputs: awready=%b wready=%b bvalid=%b grant=%b",
                         ifc.s_awready, ifc.s_wready, ifc.s_bvalid, grant_onehot);
            end
            if (mawv_f) begin
                aw_hi++;
                n_checks++;
                if (ifc.s_wready !== '0) begin
                    n_fail++;
                    $display("FAIL early_w: s_wready=%b required 0 before AW handshake", ifc.s_wready);
                end
            end
            if (ifc.m00_axi_wvalid) begin
                n_checks++;
                if (ifc.s_wready !== (ifc.m00_axi_wready ? grant_onehot : '0)) begin
                    n_fail++;
                    $display("FAIL wready_mirror: s_wready=%b wready=%b grant=%b",
                             ifc.s_wready, ifc.m00_axi_wready, grant_onehot);
                end
            end
            if (maw_f) begin
                last_aw_cycles = aw_hi;
                aw_hi = 0;
                n_checks++;
                if (exp_aw.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_order: unexpected AW addr=%0h grant=%b", ifc.m00_axi_awaddr, grant_onehot);
                end else begin
                    ea = exp_aw.pop_front();
                    if ({ifc.m00_axi_awaddr, ifc.m00_axi_awlen, grant_onehot} !== {ea.addr, ea.len, ea.gnt}) begin
                        n_fail++;
                        $display("FAIL aw_order: got addr=%0h len=%0d grant=%b required addr=%0h len=%0d grant=%b",
                                 ifc.m00_axi_awaddr, ifc.m00_axi_awlen, grant_onehot, ea.addr, ea.len, ea.gnt);
                    end
                end
            end
            if (mw_f) begin
                wbeats++;
                n_checks++;
                if (exp_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_data: unexpected beat data=%0h", ifc.m00_axi_wdata);
                end else begin
                    ew = exp_w.pop_front();
                    if ({ifc.m00_axi_wdata, ifc.m00_axi_wlast} !== {ew.data, ew.last}) begin
                        n_fail++;
                        $display("FAIL w_data: got %0h last=%b required %0h last=%b",
                                 ifc.m00_axi_wdata, ifc.m00_axi_wlast, ew.data, ew.last);
                    end
                end
            end
            for (int m = 0; m < NM; m++) begin
                if (b_f[m]) begin
                    bcount[m]++;
                    n_checks++;
                    if (ifc.s_bresp[m*2 +: 2] !== resp_val) begin
                        n_fail++;
                        $display("FAIL bresp: master %0d got %b required %b", m, ifc.s_bresp[m*2 +: 2], resp_val);
                    end
                end
            end
        end
    end

    task automatic clear_env();
        exp_aw.delete();
        exp_w.delete();
        for (int m = 0; m < NM; m++) begin
            plan_wr[m] = 0; plan_rd[m] = 0; bcount[m] = 0;
        end
        wbeats = 0; aw_hi = 0; last_aw_cycles = 0;
        aw_delay = 0; wtoggle = 1'b0; resp_val = 2'b00;
    endtask

    task automatic apply_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        clear_env();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic plan_burst(input int unsigned m, input logic [AW-1:0] addr, input logic [7:0] len,
                              input int unsigned lastpos, input logic [15:0] tag);
        burst_t b;
        b.addr = addr; b.len = len; b.lastpos = lastpos; b.tag = tag;
        plan_q[m][plan_wr[m]] = b;
        plan_wr[m]++;
    endtask

    task automatic expect_burst(input int unsigned m, input logic [AW-1:0] addr, input logic [7:0] len,
                                input int unsigned lastpos, input logic [15:0] tag);
        aw_exp_t a;
        w_exp_t  w;
        a.addr = addr; a.len = len; a.gnt = '0; a.gnt[m] = 1'b1;
        exp_aw.push_back(a);
        for (int unsigned b = 0; b <= lastpos; b++) begin
            w.data = beat_data(tag, b);
            w.last = (b == lastpos);
            exp_w.push_back(w);
        end
    endtask

    function automatic bit busy();
        for (int m = 0; m < NM; m++) begin
            if (active[m] || plan_rd[m] < plan_wr[m]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while ((exp_aw.size() != 0 || exp_w.size() != 0 || busy()) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL %s_timeout: aw left=%0d w left=%0d required 0", name, exp_aw.size(), exp_w.size());
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (grant_onehot !== '0) begin
            n_fail++; $display("FAIL reset_grant: got %b required 0", grant_onehot);
        end
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b required 0", protocol_err);
        end
        n_checks++;
        if ({ifc.m00_axi_awvalid, ifc.m00_axi_wvalid, ifc.m00_axi_bready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_m00: awvalid=%b wvalid=%b bready=%b required 0",
                     ifc.m00_axi_awvalid, ifc.m00_axi_wvalid, ifc.m00_axi_bready);
        end
        n_checks++;
        if ({ifc.s_awready, ifc.s_wready, ifc.s_bvalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_s: awready=%b wready=%b bvalid=%b required 0",
                     ifc.s_awready, ifc.s_wready, ifc.s_bvalid);
        end
        clear_env();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (grant_onehot !== '0) begin
            n_fail++; $display("FAIL idle_grant: got %b required 0", grant_onehot);
        end
    endtask

    task automatic test_single();
        apply_reset();
        plan_burst(0, 32'h1000, 8'd63, 63, 16'h0001);
        expect_burst(0, 32'h1000, 8'd63, 63, 16'h0001);
        wait_done("single");
        n_checks++;
        if (wbeats !== 64) begin n_fail++; $display("FAIL single_beats: got %0d required 64", wbeats); end
        n_checks++;
        if (bcount[0] !== 1 || bcount[1] !== 0) begin
            n_fail++; $display("FAIL single_bvalid: got %0d/%0d required 1/0", bcount[0], bcount[1]);
        end
        n_checks++;
        if (grant_onehot !== '0) begin n_fail++; $display("FAIL single_grant: got %b required 0", grant_onehot); end
        n_checks++;
        if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", protocol_err); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int unsigned k = 0; k < 2; k++) begin
            plan_burst(0, 32'h2000 + 32'(k*256), 8'd7, 7, 16'h0010 + 16'(k));
            plan_burst(1, 32'h8000 + 32'(k*256), 8'd7, 7, 16'h0020 + 16'(k));
        end
        for (int unsigned k = 0; k < 2; k++) begin
            expect_burst(0, 32'h2000 + 32'(k*256), 8'd7, 7, 16'h0010 + 16'(k));
            expect_burst(1, 32'h8000 + 32'(k*256), 8'd7, 7, 16'h0020 + 16'(k));
        end
        wait_done("simultaneous");
        n_checks++;
        if (bcount[0] !== 2 || bcount[1] !== 2) begin
            n_fail++; $display("FAIL simul_bcount: got %0d/%0d required 2/2", bcount[0], bcount[1]);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        aw_delay = 5;
        wtoggle  = 1'b1;
        plan_burst(0, 32'h3000, 8'd63, 63, 16'h0003);
        expect_burst(0, 32'h3000, 8'd63, 63, 16'h0003);
        wait_done("backpressure");
        n_checks++;
        if (wbeats !== 64) begin n_fail++; $display("FAIL bp_beats: got %0d required 64", wbeats); end
        n_checks++;
        if (last_aw_cycles !== 6) begin
            n_fail++; $display("FAIL bp_aw_wait: awvalid high %0d cycles required 6", last_aw_cycles);
        end
        n_checks++;
        if (bcount[0] !== 1 || protocol_err !== 1'b0) begin
            n_fail++; $display("FAIL bp_done: bcount=%0d err=%b required 1/0", bcount[0], protocol_err);
        end
    endtask

    task automatic test_len_mismatch();
        apply_reset();
        resp_val = 2'b10;
        plan_burst(0, 32'h4000, 8'd3, 1, 16'h0004);
        expect_burst(0, 32'h4000, 8'd3, 1, 16'h0004);
        wait_done("mismatch");
        n_checks++;
        if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_err: got %b required 1", protocol_err); end
        n_checks++;
        if (bcount[0] !== 1) begin n_fail++; $display("FAIL mismatch_b: got %0d required 1", bcount[0]); end
        plan_burst(1, 32'h4400, 8'd3, 3, 16'h0044);
        expect_burst(1, 32'h4400, 8'd3, 3, 16'h0044);
        wait_done("mismatch_after");
        n_checks++;
        if (protocol_err !== 1'b1 || bcount[1] !== 1) begin
            n_fail++; $display("FAIL mismatch_sticky: err=%b bcount=%0d required 1/1", protocol_err, bcount[1]);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n = 0;
        apply_reset();
        plan_burst(0, 32'h5000, 8'd3, 3, 16'h0050);
        expect_burst(0, 32'h5000, 8'd3, 3, 16'h0050);
        wait_done("resetmid_pre");
        wbeats = 0;
        plan_burst(0, 32'h5100, 8'd63, 63, 16'h0051);
        expect_burst(0, 32'h5100, 8'd63, 63, 16'h0051);
        while (wbeats < 10 && n < 500) begin @(posedge clk); n++; end
        n_checks++;
        if (n >= 500) begin n_fail++; $display("FAIL resetmid_wait: beats=%0d required 10", wbeats); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({grant_onehot, protocol_err, ifc.m00_axi_awvalid, ifc.m00_axi_wvalid, ifc.m00_axi_bready,
             ifc.s_awready, ifc.s_wready, ifc.s_bvalid} !== '0) begin
            n_fail++;
            $display("FAIL resetmid_outputs: grant=%b err=%b m00 aw/w/b=%b%b%b s aw/w/b=%b/%b/%b required 0",
                     grant_onehot, protocol_err, ifc.m00_axi_awvalid, ifc.m00_axi_wvalid, ifc.m00_axi_bready,
                     ifc.s_awready, ifc.s_wready, ifc.s_bvalid);
        end
        clear_env();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        // The completed pre-reset burst moved the pointer to 1; after reset master0 must win again.
        plan_burst(0, 32'h5200, 8'd3, 3, 16'h0052);
        plan_burst(1, 32'h9200, 8'd3, 3, 16'h0092);
        expect_burst(0, 32'h5200, 8'd3, 3, 16'h0052);
        expect_burst(1, 32'h9200, 8'd3, 3, 16'h0092);
        wait_done("resetmid_post");
        n_checks++;
        if (bcount[0] !== 1 || bcount[1] !== 1) begin
            n_fail++; $display("FAIL resetmid_b: got %0d/%0d required 1/1", bcount[0], bcount[1]);
        end
    endtask

    task automatic test_starvation();
        int unsigned n = 0;
        apply_reset();
        for (int unsigned k = 0; k < 3; k++) plan_burst(0, 32'h6000 + 32'(k*64), 8'd3, 3, 16'h0060 + 16'(k));
        expect_burst(0, 32'h6000, 8'd3, 3, 16'h0060);
        while (exp_aw.size() != 0 && n < 200) begin @(posedge clk); n++; end
        n_checks++;
        if (n >= 200) begin n_fail++; $display("FAIL starve_first_aw: pending=%0d required 0", exp_aw.size()); end
        plan_burst(1, 32'hA000, 8'd3, 3, 16'h0070);
        expect_burst(1, 32'hA000, 8'd3, 3, 16'h0070);
        expect_burst(0, 32'h6040, 8'd3, 3, 16'h0061);
        expect_burst(0, 32'h6080, 8'd3, 3, 16'h0062);
        wait_done("starvation");
        n_checks++;
        if (bcount[0] !== 3 || bcount[1] !== 1) begin
            n_fail++; $display("FAIL starve_b: got %0d/%0d required 3/1", bcount[0], bcount[1]);
        end
    endtask

    initial begin
        clear_env();
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_len_mismatch();
        test_reset_mid();
        test_starvation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
